bsg_segment_accumulator: RTL

//  Merges partial-width writes into one full-width word, segment by segment, then

---
 rtl/bsg_segment_accumulator_pkg.sv | 14 +
 rtl/bsg_mux_segmented.sv | 18 +
 rtl/bsg_segment_accumulator.sv | 87 ++++++++
 3 files changed

// File: rtl/bsg_segment_accumulator_pkg.sv
// Shared types and helpers for the segment accumulator.
package bsg_segment_accumulator_pkg;

  typedef enum logic {
    eFill = 1'b0,
    eHold = 1'b1
  } state_e;

  // Guards the divide so a bad parameter set reaches the elaboration check cleanly.
  function automatic int seg_width(input int width_p, input int segments_p);
    return (segments_p < 1) ? width_p : (width_p / segments_p);
  endfunction

endpackage

// File: rtl/bsg_mux_segmented.sv
// Per-segment 2:1 select: segment k takes data1 when sel[k]=1, otherwise data0.
module bsg_mux_segmented #(
  parameter int segments_p      = 4,
  parameter int segment_width_p = 4
) (
  input  logic [segments_p*segment_width_p-1:0] data0_i,
  input  logic [segments_p*segment_width_p-1:0] data1_i,
  input  logic [segments_p-1:0]                 sel_i,
  output logic [segments_p*segment_width_p-1:0] data_o
);

  for (genvar k = 0; k < segments_p; k++) begin : g_seg
    assign data_o[k*segment_width_p +: segment_width_p] = sel_i[k]
      ? data1_i[k*segment_width_p +: segment_width_p]
      : data0_i[k*segment_width_p +: segment_width_p];
  end

endmodule

// File: rtl/bsg_segment_accumulator.sv
// Assembles a full-width word from masked partial writes and offers it
// downstream on a v/yumi handshake.
module bsg_segment_accumulator
  import bsg_segment_accumulator_pkg::*;
#(
  parameter int width_p         = 16,
  parameter int segments_p      = 4,
  parameter bit clear_on_emit_p = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  v_i,
  input  logic [width_p-1:0]    data_i,
  input  logic [segments_p-1:0] seg_mask_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic                  v_o,
  output logic [width_p-1:0]    data_o,
  output logic [segments_p-1:0] filled_o,
  input  logic                  yumi_i
);

  localparam int seg_width_lp = seg_width(width_p, segments_p);

  if ((segments_p < 1)
      || ((width_p % ((segments_p < 1) ? 1 : segments_p)) != 0)) begin : g_bad_params
    $error("bsg_segment_accumulator: width_p must be a multiple of segments_p >= 1");
  end

  state_e                state_r;
  logic [width_p-1:0]    data_r;
  logic [width_p-1:0]    data_n;
  logic [segments_p-1:0] filled_r;
  logic                  closes;

  bsg_mux_segmented #(
    .segments_p     (segments_p),
    .segment_width_p(seg_width_lp)
  ) u_mux (
    .data0_i(data_r),
    .data1_i(data_i),
    .sel_i  (seg_mask_i),
    .data_o (data_n)
  );

  // A write completes the word if it is flagged last or fills the final gaps.
  assign closes = last_i | (&(filled_r | seg_mask_i));

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= eFill;
      data_r   <= '0;
      filled_r <= '0;
    end else begin
      case (state_r)
        eFill: begin
          if (v_i) begin
            data_r   <= data_n;
            filled_r <= filled_r | seg_mask_i;
            if (closes) state_r <= eHold;
          end
        end
        eHold: begin
          if (yumi_i) begin
            state_r  <= eFill;
            filled_r <= '0;
            if (clear_on_emit_p) data_r <= '0;
          end
        end
        default: state_r <= eFill;
      endcase
    end
  end

  // Handshake outputs decode the state flop only; yumi never reaches ready.
  assign ready_o  = (state_r == eFill);
  assign v_o      = (state_r == eHold);
  assign data_o   = data_r;
  assign filled_o = filled_r;

  yumi_only_in_hold: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> (state_r == eHold)
  );

endmodule
